// File: rtl/s2p_pkg.sv
// Shared types for the s2p write-side frame scheduler.
// State encoding and default word width.
package s2p_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } s2p_sched_st_e;

    localparam int S2P_DW = 8;

endpackage

// File: rtl/s2p_frame_sched_if.sv
// Requester bus and serial write port of the s2p frame scheduler.
// master = scheduler side, slave = requesters / s2p side.
interface s2p_frame_sched_if
    import s2p_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = S2P_DW
);

    logic [NREQ-1:0]         req;
    logic [NREQ*DW-1:0]      wdata;
    logic [NREQ-1:0]         gnt;
    logic                    wra_n;
    logic                    da;
    logic                    busy;
    logic [$clog2(NREQ)-1:0] cur_id;

    modport master (
        input  req,
        input  wdata,
        output gnt,
        output wra_n,
        output da,
        output busy,
        output cur_id
    );

    modport slave (
        output req,
        output wdata,
        input  gnt,
        input  wra_n,
        input  da,
        input  busy,
        input  cur_id
    );

endinterface

// File: rtl/s2p_frame_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter
    import s2p_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_vld
);

    localparam int IW = $clog2(NREQ);

    // Scan farthest-first so the candidate closest to ptr wins last.
    always_comb begin
        int w_pos;
        o_idx = '0;
        o_vld = 1'b0;
        o_gnt = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (i_req[w_pos]) begin
                o_idx = IW'(w_pos);
                o_vld = 1'b1;
            end
        end
        if (o_vld) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/s2p_frame_sched.sv
// Round-robin frame scheduler driving the s2p serial write port:
// grant, shift DW bits MSB first with wra_n low, then hold an idle gap.
module s2p_frame_sched
    import s2p_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = S2P_DW,
    parameter int GAP  = 2
) (
    input logic               clka,
    input logic               rstn,
    s2p_frame_sched_if.master bus
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_SHIFT = 2'(ST_SHIFT);
    localparam logic [1:0] S_GAP   = 2'(ST_GAP);

    logic [1:0]      r_state;
    logic [IW-1:0]   r_ptr;
    logic [BW-1:0]   r_bcnt;
    logic [GW-1:0]   r_gcnt;
    logic [DW-1:0]   r_sreg;
    logic [NREQ-1:0] r_gnt;
    logic            r_wra_n;
    logic            r_da;
    logic            r_busy;
    logic [IW-1:0]   r_cur_id;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_vld;
    logic [DW-1:0]   w_word;
    logic [IW-1:0]   w_ptr_nxt;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

    assign w_word    = bus.wdata[int'(w_idx)*DW +: DW];
    assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    // MSB goes straight to da; sreg holds the remaining bits left-aligned.
    always_ff @(posedge clka) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_bcnt   <= '0;
            r_gcnt   <= '0;
            r_sreg   <= '0;
            r_gnt    <= '0;
            r_wra_n  <= 1'b1;
            r_da     <= 1'b0;
            r_busy   <= 1'b0;
            r_cur_id <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_vld) begin
                        r_sreg   <= {w_word[DW-2:0], 1'b0};
                        r_gnt    <= w_gnt;
                        r_wra_n  <= 1'b0;
                        r_da     <= w_word[DW-1];
                        r_cur_id <= w_idx;
                        r_ptr    <= w_ptr_nxt;
                        r_bcnt   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_bcnt == BW'(DW - 1)) begin
                        r_wra_n <= 1'b1;
                        r_da    <= 1'b0;
                        r_gcnt  <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_da   <= r_sreg[DW-1];
                        r_sreg <= {r_sreg[DW-2:0], 1'b0};
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gcnt == GW'(GAP - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: begin
                    r_wra_n <= 1'b1;
                    r_da    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.wra_n  = r_wra_n;
    assign bus.da     = r_da;
    assign bus.busy   = r_busy;
    assign bus.cur_id = r_cur_id;

endmodule

// File: tb/tb_s2p_frame_sched.sv
// Bench for s2p_frame_sched: directed scenarios plus random traffic,
// checked against a frame-timeline model and an s2p receiver model.
module tb_s2p_frame_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int GAP  = 2;
    localparam int PER  = DW + GAP + 1;

    logic clka = 1'b0;
    logic rstn = 1'b0;

    always #5 clka = ~clka;

    s2p_frame_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

    s2p_frame_sched #(
        .NREQ (NREQ),
        .DW   (DW),
        .GAP  (GAP)
    ) dut (
        .clka (clka),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] words [NREQ];

    // timeline model: start edge of the current frame, rr pointer, word
    int            m_ptr   = 0;
    int            m_cur   = 0;
    int            m_start = -100;
    logic [DW-1:0] m_word  = '0;

    // s2p receiver model
    logic [DW-1:0] s_sh   = '0;
    int            s_n    = 0;
    logic          s_low  = 1'b0;
    logic [DW-1:0] db     = '0;
    int            lowlen = 0;

    int            gl   [$];
    int            gcyc [$];
    logic [DW-1:0] dbl  [$];
    logic          pend [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] rq;
        logic            rs;
        logic [DW-1:0]   ws [NREQ];
        int              off;
        int              sel;
        logic            elow;
        logic            eda;
        for (int i = 0; i < NREQ; i++) begin
            bus.wdata[i*DW +: DW] = words[i];
            ws[i] = words[i];
        end
        rq = bus.req;
        rs = rstn;
        @(posedge clka);
        #1;
        cyc++;
        if (!rs) begin
            m_ptr   = 0;
            m_cur   = 0;
            m_start = -100;
        end else if (rq != 0 && cyc - m_start >= PER) begin
            sel = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (sel < 0 && rq[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
            end
            m_cur   = sel;
            m_ptr   = (sel + 1) % NREQ;
            m_start = cyc;
            m_word  = ws[sel];
        end
        off  = cyc - m_start;
        elow = (off >= 0 && off < DW);
        eda  = elow ? m_word[DW-1-off] : 1'b0;
        if (bus.wra_n === 1'b0) begin
            s_sh = {s_sh[DW-2:0], bus.da};
            s_n++;
        end else if (s_low) begin
            db     = s_sh;
            lowlen = s_n;
            s_n    = 0;
        end
        s_low = (bus.wra_n === 1'b0);
        chk("gnt", 32'(bus.gnt), (off == 0) ? 32'(1 << m_cur) : 32'd0);
        chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        chk("wra_n", 32'(bus.wra_n), 32'(!elow));
        chk("da", 32'(bus.da), 32'(eda));
        chk("busy", 32'(bus.busy), 32'(off >= 0 && off < DW + GAP));
        chk("cur_id", 32'(bus.cur_id), 32'(m_cur));
        if (off == DW) begin
            chk("db", 32'(db), 32'(m_word));
            chk("wra_n_len", 32'(lowlen), 32'(DW));
            dbl.push_back(db);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i] === 1'b1) begin
                gl.push_back(i);
                gcyc.push_back(cyc);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int i = 0; i < budget && gl.size() < n; i++) step();
        chk("grant_timeout", 32'(gl.size() >= n), 32'd1);
    endtask

    task automatic clr_logs();
        gl.delete();
        gcyc.delete();
        dbl.delete();
    endtask

    initial begin
        bus.req   = '0;
        bus.wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            words[i] = '0;
            pend[i]  = 1'b0;
        end

        // reset state
        rstn = 1'b0;
        run(3);
        chk("rst_wra_n", 32'(bus.wra_n), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // single requester, A5
        rstn     = 1'b1;
        words[0] = 8'hA5;
        bus.req  = 4'b0001;
        step();
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        run(PER + 1);
        chk("t1_db", 32'(db), 32'hA5);
        chk("t1_len", 32'(lowlen), 32'(DW));

        // all four requesting from a fresh pointer
        rstn = 1'b0;
        step();
        rstn     = 1'b1;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        words[3] = 8'h44;
        clr_logs();
        bus.req = 4'b1111;
        wait_grants(5, 80);
        bus.req = '0;
        run(PER + 1);
        for (int i = 0; i < gl.size(); i++) chk("t2_order", 32'(gl[i]), 32'(i % NREQ));
        for (int i = 1; i < gcyc.size(); i++) chk("t2_period", 32'(gcyc[i] - gcyc[i-1]), 32'(PER));
        chk("t2_frames", 32'(dbl.size()), 32'd5);
        for (int i = 0; i < dbl.size(); i++) chk("t2_db", 32'(dbl[i]), 32'(8'h11 * ((i % NREQ) + 1)));

        // pointer wrap: 2 first, then 0 ahead of 2
        clr_logs();
        bus.req = 4'b0100;
        step();
        chk("t3_gnt2", 32'(bus.gnt), 32'h4);
        bus.req = 4'b0101;
        clr_logs();
        wait_grants(2, 40);
        if (gl.size() >= 2) begin
            chk("t3_second", 32'(gl[0]), 32'd0);
            chk("t3_third", 32'(gl[1]), 32'd2);
        end
        bus.req = '0;
        run(PER + 1);

        // reset in the middle of a frame
        words[1] = 8'hC3;
        bus.req  = 4'b0010;
        step();
        chk("t4_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        run(4);
        rstn = 1'b0;
        step();
        chk("t4_wra_n", 32'(bus.wra_n), 32'd1);
        chk("t4_da", 32'(bus.da), 32'd0);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        chk("t4_cur", 32'(bus.cur_id), 32'd0);
        rstn    = 1'b1;
        bus.req = 4'b1111;
        step();
        chk("t4_restart", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        run(PER + 1);

        // req drop and wdata change right after the grant
        words[3] = 8'h5A;
        bus.req  = 4'b1000;
        step();
        chk("t5_gnt", 32'(bus.gnt), 32'h8);
        words[3] = 8'hFF;
        bus.req  = '0;
        run(PER);
        chk("t5_db", 32'(db), 32'h5A);

        // random traffic with withdrawals and rare resets
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    words[i] = DW'($urandom);
                end else if (pend[i] && $urandom_range(0, 39) == 0) begin
                    pend[i] = 1'b0;
                end
                bus.req[i] = pend[i];
            end
            rstn = ($urandom_range(0, 199) != 0);
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i] === 1'b1) begin
                    pend[i]  = 1'b0;
                    words[i] = DW'($urandom);
                end
            end
        end
        rstn    = 1'b1;
        bus.req = '0;
        run(PER + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
